// File: rtl/servo_led_if.sv
// servo_led_if: board-facing servo PWM and RGB LED pin bundle
interface servo_led_if;
  logic [2:0] gpio;
  logic       led_red;
  logic       led_green;
  logic       led_blue;
  modport master (output gpio, led_red, led_green, led_blue);
  modport slave  (input  gpio, led_red, led_green, led_blue);
endinterface

// File: rtl/servo_led_gpio_top.sv
// servo_led_gpio_top: three triangle-sweeping RC-servo PWM channels with LED brightness tracking each position
module servo_led_gpio_top #(
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int PULSE_MIN    = 50_000,
  parameter int PULSE_MAX    = 100_000,
  parameter int STEP         = 1_000,
  parameter int LED_SCALE    = 5
) (
  input  logic         clk,
  input  logic         rst_in,
  servo_led_if.master  io
);
  localparam int IDX_MAX = (PULSE_MAX - PULSE_MIN) / STEP;
  localparam int FW      = $clog2(FRAME_CYCLES);
  localparam int IW      = IDX_MAX > 0 ? $clog2(IDX_MAX + 1) : 1;
  logic [1:0]    sync;
  logic          rst_n;
  logic [FW-1:0] frame_cnt;
  logic [7:0]    led_cnt;
  logic          frame_end;
  logic [FW-1:0] pulse [3];
  logic [7:0]    duty  [3];
  // Assertion follows rst_in at once; release is retimed to clk.
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) sync <= '0;
    else         sync <= {sync[0], 1'b1};
  assign rst_n     = sync[1];
  assign frame_end = frame_cnt == FW'(FRAME_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      led_cnt   <= '0;
    end else begin
      frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
      led_cnt   <= led_cnt + 1'b1;
    end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam int I0 = i == 0 ? 0 : (i == 1 ? IDX_MAX / 2 : IDX_MAX);
    localparam bit D0 = i == 2;
    logic [IW-1:0] idx;
    logic          dn;
    // Bounce off the ends so each bound is held for exactly one frame.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        idx <= IW'(I0);
        dn  <= D0;
      end else if (frame_end) begin
        if (!dn) begin
          idx <= idx == IW'(IDX_MAX) ? idx - 1'b1 : idx + 1'b1;
          dn  <= idx == IW'(IDX_MAX);
        end else begin
          idx <= idx == '0 ? idx + 1'b1 : idx - 1'b1;
          dn  <= idx != '0;
        end
      end
    assign pulse[i] = FW'(PULSE_MIN) + FW'(idx) * FW'(STEP);
    assign duty[i]  = 8'(idx) * 8'(LED_SCALE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      io.gpio      <= '0;
      io.led_red   <= 1'b1;
      io.led_green <= 1'b1;
      io.led_blue  <= 1'b1;
    end else begin
      io.gpio      <= {frame_cnt < pulse[2], frame_cnt < pulse[1], frame_cnt < pulse[0]};
      io.led_red   <= ~(led_cnt < duty[0]);
      io.led_green <= ~(led_cnt < duty[1]);
      io.led_blue  <= ~(led_cnt < duty[2]);
    end
endmodule

// File: tb/tb_servo_led_gpio_top.sv
// tb_servo_led_gpio_top: per-frame scoreboard of servo pulse widths and LED on-time against a triangle-sweep model
module tb_servo_led_gpio_top;
  localparam int F = 600, PMIN = 100, PMAX = 400, ST = 50, S = 40;
  localparam int M = (PMAX - PMIN) / ST;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  int checks = 0, errors = 0;
  int exp_q[$];
  bit run = 1'b0;
  int frames_done = 0;
  servo_led_if io ();
  servo_led_gpio_top #(.FRAME_CYCLES(F), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX),
                       .STEP(ST), .LED_SCALE(S)) dut (.clk(clk), .rst_in(rst_in), .io(io));
  always #5 clk = ~clk;
  function automatic int tri_idx(int c, int f);
    int ph = c == 0 ? 0 : (c == 1 ? M / 2 : M);
    int p  = (ph + f) % (2 * M);
    return p <= M ? p : 2 * M - p;
  endfunction
  function automatic int led_on(int f, int d);
    int n = 0;
    for (int j = 0; j < F; j++) if (((f * F + j) % 256) < d) n++;
    return n;
  endfunction
  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic push_model(int nf);
    exp_q.delete();
    for (int f = 0; f < nf; f++)
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back(PMIN + tri_idx(c, f) * ST);
        exp_q.push_back(led_on(f, tri_idx(c, f) * S));
      end
  endtask
  // Monitor: frames delimited by gpio[0] rising edges; a closed frame is scored.
  bit started = 1'b0, prev0 = 1'b0;
  int n_smp = 0;
  int hi[3], lo[3];
  always @(negedge clk) begin
    if (!run) begin
      started = 1'b0;
      prev0 = 1'b0;
    end else begin
      if (io.gpio[0] && !prev0) begin
        if (started) begin
          check("frame_spacing", n_smp, F);
          for (int c = 0; c < 3; c++) begin
            if (exp_q.size() < 2) check("queue_underflow", exp_q.size(), 2);
            else begin
              check($sformatf("gpio%0d_width_f%0d", c, frames_done), hi[c], exp_q.pop_front());
              check($sformatf("led%0d_on_f%0d", c, frames_done), lo[c], exp_q.pop_front());
            end
          end
          frames_done++;
        end
        started = 1'b1;
        n_smp = 0;
        for (int c = 0; c < 3; c++) begin hi[c] = 0; lo[c] = 0; end
      end
      if (started) begin
        n_smp++;
        for (int c = 0; c < 3; c++) hi[c] += int'(io.gpio[c]);
        lo[0] += int'(!io.led_red);
        lo[1] += int'(!io.led_green);
        lo[2] += int'(!io.led_blue);
      end
      prev0 = io.gpio[0];
    end
  end
  task automatic check_reset(string name);
    check({name, "_gpio"}, int'(io.gpio), 0);
    check({name, "_leds"}, int'({io.led_blue, io.led_green, io.led_red}), 7);
  endtask
  task automatic release_run(int nf);
    @(negedge clk);
    #1;
    push_model(nf);
    frames_done = 0;
    rst_in = 1'b1;
    run = 1'b1;
  endtask
  initial begin
    repeat (4) @(negedge clk);
    check_reset("hold_reset");
    release_run(9);
    repeat (2 + 9 * F + 10) @(posedge clk);
    check("run1_frames", frames_done, 9);
    @(posedge clk);
    #2;
    rst_in = 1'b0;
    run = 1'b0;
    #1;
    check_reset("reset_between_runs");
    repeat (3) @(negedge clk);
    release_run(12);
    repeat (2 + 3 * F + 50) @(posedge clk);
    #2;
    check("midpulse_gpio2", int'(io.gpio[2]), 1);
    rst_in = 1'b0;
    run = 1'b0;
    #1;
    check_reset("async_reset");
    check("run2_frames_before_reset", frames_done, 3);
    repeat (5) @(negedge clk);
    check_reset("held_after_async");
    release_run(5);
    repeat (2 + 5 * F + 10) @(posedge clk);
    check("run3_frames", frames_done, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
